// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the unified memory port arbiter:
//   - arb_state_t : arbiter FSM states (IDLE / FETCH / DATA)
//   - grant_t     : round-robin owner encoding (GRANT_FETCH / GRANT_DATA)
//   - DEF_ADDR_W / DEF_DATA_W / DEF_MAX_WAIT : parameter defaults
//   - WAIT_CNT_W  : width of the wait counter (covers MAX_WAIT up to 255)
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 15;
  localparam int WAIT_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  typedef logic grant_t;

  localparam grant_t GRANT_FETCH = 1'b0;
  localparam grant_t GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles in which a memory request is outstanding but unacknowledged
// and flags the cycle on which the MAX_WAIT-th such cycle completes.
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   clr      in  restart the count (a new request is being granted)
//   en       in  one waiting cycle (mem_req & ~mem_ack)
//   expired  out high during the waiting cycle that brings the count to
//                MAX_WAIT; the owner drops the request on that edge
// -----------------------------------------------------------------------------
module mem_wait_timer
  import cpu_mem_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count holds the number of waiting cycles already completed, so the
  // terminal compare is against MAX_WAIT-1 while the final one is in flight.
  localparam logic [WAIT_CNT_W-1:0] TERM = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en & (cnt == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single unified memory port between instruction fetch (IF) and
// the MEM-stage data access. Owns the mem_req/mem_ack handshake, returns
// read data to the winning requester, raises stalls while a requester waits
// and aborts a transaction that waits MAX_WAIT cycles (sticky timeout_err).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   if_req/if_addr    fetch request (level) and PC
//   if_rdata/if_valid fetched instruction and one-cycle completion pulse
//   d_read/d_write    data access request (both high = write)
//   d_addr/d_wdata    data address and store data
//   d_rdata/d_valid   load data and one-cycle completion pulse
//   stall_if          fetch pending and not completing this cycle
//   stall_mem         data access pending and not completing this cycle
//   mem_req/mem_we    memory request (held until ack) and write enable
//   mem_addr/mem_wdata registered address and write data
//   mem_ack/mem_rdata memory completion and read data
//   timeout_err       sticky flag: some access timed out since reset
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  arb_state_t state;
  grant_t     last_grant;

  logic d_pend;
  logic grant_any;
  logic grant_data;
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  assign d_pend    = d_read | d_write;
  assign grant_any = d_pend | if_req;

  // Data wins when it is alone, or on a tie when fetch was served last.
  assign grant_data = d_pend & (~if_req | (last_grant == GRANT_FETCH));

  assign timer_clr = (state == IDLE) & grant_any;
  assign timer_en  = mem_req & ~mem_ack;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Stalls depend only on request inputs and the registered valids, so
  // mem_ack never reaches an output combinationally.
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_pend & ~d_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GRANT_FETCH;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_valid    <= 1'b0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_any) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_data & d_write;
            mem_addr  <= grant_data ? d_addr : if_addr;
            mem_wdata <= d_wdata;
            state     <= grant_data ? DATA : FETCH;
          end
        end

        // The request inputs are not consulted while busy: a withdrawn
        // request still completes and still receives its valid pulse.
        FETCH: begin
          if (mem_ack || timer_expired) begin
            mem_req    <= 1'b0;
            state      <= IDLE;
            if_valid   <= 1'b1;
            last_grant <= GRANT_FETCH;
            if (mem_ack) begin
              if_rdata <= mem_rdata;
            end else begin
              if_rdata    <= '0;
              timeout_err <= 1'b1;
            end
          end
        end

        DATA: begin
          if (mem_ack || timer_expired) begin
            mem_req    <= 1'b0;
            state      <= IDLE;
            d_valid    <= 1'b1;
            last_grant <= GRANT_DATA;
            if (mem_ack) begin
              // A completed store leaves the last load value in place.
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              d_rdata     <= '0;
              timeout_err <= 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench. Stimulus pushes the expected memory requests and the
// expected completions into queues; a memory model pops and checks each new
// memory request (and its stability while waiting), and a monitor pops and
// checks each if_valid/d_valid pulse. A second instance with MAX_WAIT=4 and
// a never-acking memory exercises the timeout path with directed checks.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        is_data;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst_n;

  // main instance
  logic        if_req, d_read, d_write, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, stall_if, stall_mem, mem_req, mem_we, timeout_err;

  // timeout instance
  logic        t_if_req, t_d_read, t_d_write, t_mem_ack;
  logic [31:0] t_if_addr, t_d_addr, t_d_wdata, t_mem_rdata;
  logic [31:0] t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_if_valid, t_d_valid, t_stall_if, t_stall_mem, t_mem_req, t_mem_we, t_timeout_err;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ack_lat = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .if_req(t_if_req), .if_addr(t_if_addr), .if_rdata(t_if_rdata), .if_valid(t_if_valid),
    .d_read(t_d_read), .d_write(t_d_write), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
    .d_rdata(t_d_rdata), .d_valid(t_d_valid),
    .stall_if(t_stall_if), .stall_mem(t_stall_mem),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata), .timeout_err(t_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic exp_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic is_data, input logic [31:0] data);
    rsp_t r;
    r.is_data = is_data; r.data = data;
    rsp_q.push_back(r);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h2108000A;
      32'h80:  return 32'h11112222;
      32'h84:  return 32'h55556666;
      32'h300: return 32'h33334444;
      32'h304: return 32'h77778888;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Memory model: acks ack_lat cycles after mem_req first rises.
  initial begin
    int   w;
    req_t e;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    w = 0; h_we = 0; h_addr = 0; h_wdata = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0BAD0BAD;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (w == 0) begin
          if (req_q.size() == 0) begin
            fail_now("unexpected_mem_req");
          end else begin
            e = req_q.pop_front();
            chk("req_we", {31'd0, mem_we}, {31'd0, e.we});
            chk("req_addr", mem_addr, e.addr);
            if (e.we) chk("req_wdata", mem_wdata, e.wdata);
          end
          h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
        end else begin
          chk("hold_we", {31'd0, mem_we}, {31'd0, h_we});
          chk("hold_addr", mem_addr, h_addr);
          chk("hold_wdata", mem_wdata, h_wdata);
        end
        if (w == ack_lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 32'h0BAD0BAD;
        end
        w++;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0BAD0BAD;
        w = 0;
      end
    end
  end

  // Completion monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        if (rsp_q.size() == 0) fail_now("unexpected_if_valid");
        else begin
          r = rsp_q.pop_front();
          chk("rsp_owner_fetch", {31'd0, r.is_data}, 32'd0);
          chk("if_rdata", if_rdata, r.data);
        end
      end
      if (d_valid === 1'b1) begin
        if (rsp_q.size() == 0) fail_now("unexpected_d_valid");
        else begin
          r = rsp_q.pop_front();
          chk("rsp_owner_data", {31'd0, r.is_data}, 32'd1);
          chk("d_rdata", d_rdata, r.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tie(input int rounds);
    logic [31:0] dd [2];
    logic [31:0] fd [2];
    int dcnt, fcnt, cyc;
    dd = '{32'h33334444, 32'h77778888};
    fd = '{32'h11112222, 32'h55556666};
    dcnt = 0; fcnt = 0; cyc = 0;
    ack_lat = 0;
    for (int k = 0; k < rounds; k++) begin
      exp_req(1'b0, 32'h300 + 32'(4 * k), 32'h0);
      exp_rsp(1'b1, dd[k]);
      exp_req(1'b0, 32'h80 + 32'(4 * k), 32'h0);
      exp_rsp(1'b0, fd[k]);
    end
    d_read = 1'b1; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h80;
    while ((dcnt < rounds || fcnt < rounds) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (d_valid) begin
        dcnt++;
        if (dcnt < rounds) d_addr = d_addr + 32'd4; else d_read = 1'b0;
      end
      if (if_valid) begin
        fcnt++;
        if (fcnt < rounds) if_addr = if_addr + 32'd4; else if_req = 1'b0;
      end
    end
    if (dcnt < rounds || fcnt < rounds) fail_now("tie_completion");
    else chk("tie_cycles", cyc, 32'(4 * rounds));
  endtask

  initial begin
    int cyc, reqcyc, vcnt;
    bit done;
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    t_if_req = 0; t_if_addr = 0; t_d_read = 0; t_d_write = 0; t_d_addr = 0;
    t_d_wdata = 0; t_mem_ack = 0; t_mem_rdata = 32'h12345678;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_timeout_err", {31'd0, t_timeout_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // fetch only, ack in the 4th request cycle
    ack_lat = 3;
    exp_req(1'b0, 32'h40, 32'h0);
    exp_rsp(1'b0, 32'h2108000A);
    if_req = 1'b1; if_addr = 32'h40;
    cyc = 0; done = 0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (if_valid) begin
        done = 1;
        chk("fetch_stall_at_valid", {31'd0, stall_if}, 32'd0);
        chk("fetch_latency", cyc, 32'd5);
        if_req = 1'b0;
      end else begin
        chk("fetch_stall_if", {31'd0, stall_if}, 32'd1);
      end
    end
    if (!done) fail_now("fetch_completion");
    @(negedge clk);

    // tie after reset: D, F, D, F
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tie(2);
    @(negedge clk);

    // request withdrawn after grant
    ack_lat = 2;
    exp_req(1'b0, 32'h40, 32'h0);
    exp_rsp(1'b0, 32'h2108000A);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("wd_mem_req", {31'd0, mem_req}, 32'd1);
    if_req = 1'b0;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (if_valid) vcnt++;
    end
    chk("wd_valid_count", vcnt, 32'd1);
    chk("wd_mem_req_idle", {31'd0, mem_req}, 32'd0);

    // store with 5 wait cycles; d_rdata keeps the last load value
    ack_lat = 5;
    exp_req(1'b1, 32'h100, 32'hCAFEF00D);
    exp_rsp(1'b1, 32'h77778888);
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFEF00D;
    cyc = 0; done = 0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (d_valid) begin
        done = 1;
        chk("store_latency", cyc, 32'd7);
        chk("store_stall_at_valid", {31'd0, stall_mem}, 32'd0);
        d_write = 1'b0;
      end else begin
        chk("store_stall_mem", {31'd0, stall_mem}, 32'd1);
      end
    end
    if (!done) fail_now("store_completion");
    @(negedge clk);

    // timeout on the MAX_WAIT=4 instance
    t_d_read = 1'b1; t_d_addr = 32'h500;
    cyc = 0; reqcyc = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (t_mem_req) reqcyc++;
      if (t_d_valid) done = 1;
    end
    if (!done) fail_now("to_valid");
    else begin
      chk("to_req_cycles", reqcyc, 32'd4);
      chk("to_latency", cyc, 32'd5);
      chk("to_mem_req_dropped", {31'd0, t_mem_req}, 32'd0);
      chk("to_d_rdata", t_d_rdata, 32'd0);
      chk("to_err", {31'd0, t_timeout_err}, 32'd1);
    end
    t_d_read = 1'b0;
    t_if_req = 1'b1; t_if_addr = 32'h44;
    @(negedge clk);
    chk("to_fetch_req", {31'd0, t_mem_req}, 32'd1);
    chk("to_fetch_addr", t_mem_addr, 32'h44);
    chk("to_fetch_we", {31'd0, t_mem_we}, 32'd0);
    t_mem_ack = 1'b1;
    @(negedge clk);
    t_mem_ack = 1'b0;
    chk("to_fetch_valid", {31'd0, t_if_valid}, 32'd1);
    chk("to_fetch_rdata", t_if_rdata, 32'h12345678);
    chk("to_err_sticky", {31'd0, t_timeout_err}, 32'd1);
    t_if_req = 1'b0;
    @(negedge clk);

    // reset in the middle of a data read
    ack_lat = 100;
    exp_req(1'b0, 32'h300, 32'h0);
    d_read = 1'b1; d_addr = 32'h300;
    repeat (2) @(negedge clk);
    chk("rm_req_before", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rm_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rm_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rm_mem_addr", mem_addr, 32'd0);
    chk("rm_timeout_err", {31'd0, t_timeout_err}, 32'd0);
    d_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tie(1);

    cyc = 0;
    while ((req_q.size() != 0 || rsp_q.size() != 0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
